// File: rtl/gf180mcu_osu_sc_tbuf_pkg.sv
// Shared definitions for the tristate-bus controller.
//   bus_state_e : controller state (IDLE, DRIVE, TURN)
//   cnt_width() : width of the shared hold/dead-time counter
package gf180mcu_osu_sc_tbuf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } bus_state_e;

    // One counter serves both the DRIVE hold time and the TURN gap, so it
    // must reach the larger of the two limits.
    function automatic int cnt_width(input int dead, input int max_hold);
        int m;
        m = (dead > max_hold) ? dead : max_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_rr_arb.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index of the last winner; the search starts at ptr+1 (mod NDRV)
//   gnt : one-hot winner (zero when no request)
//   vld : at least one request present
module gf180mcu_osu_sc_rr_arb #(
    parameter int NDRV = 4
) (
    input  logic [NDRV-1:0]         req,
    input  logic [$clog2(NDRV)-1:0] ptr,
    output logic [NDRV-1:0]         gnt,
    output logic                    vld
);
    localparam int PW = $clog2(NDRV);

    logic [PW-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        // Visit ptr+1 .. ptr+NDRV; the last candidate is the previous winner.
        for (int i = 1; i <= NDRV; i++) begin
            if (int'(ptr) + i >= NDRV) idx = PW'(int'(ptr) + i - NDRV);
            else                       idx = PW'(int'(ptr) + i);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_tbuf_bus_ctrl.sv
// Shared tristate-bus controller: round-robin ownership, complementary
// tbuf enables, a DEAD-cycle all-off gap between owners and a keeper
// register on the received bus value.
//   CLK, RN  : clock, asynchronous active-low reset
//   REQ      : per-driver level request
//   BUS_IN   : resolved bus value at the receiver
//   GNT/EN   : one-hot (or zero) grant and tbuf enable
//   EN_BAR   : complement of EN
//   BUS_Q    : captured bus value, held when nobody drives
//   BUS_VLD  : BUS_Q was loaded from a driven bus in the last cycle
module gf180mcu_osu_sc_12t_tbuf_bus_ctrl
    import gf180mcu_osu_sc_tbuf_pkg::*;
#(
    parameter int NDRV     = 4,
    parameter int W        = 8,
    parameter int DEAD     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic [NDRV-1:0] REQ,
    input  logic [W-1:0]    BUS_IN,
    output logic [NDRV-1:0] GNT,
    output logic [NDRV-1:0] EN,
    output logic [NDRV-1:0] EN_BAR,
    output logic [W-1:0]    BUS_Q,
    output logic            BUS_VLD
);
    localparam int PW = $clog2(NDRV);
    localparam int CW = cnt_width(DEAD, MAX_HOLD);

    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
    // With unlimited hold the counter just parks at all-ones.
    localparam logic [CW-1:0] HOLD_SAT  = (MAX_HOLD != 0) ? CW'(MAX_HOLD) : {CW{1'b1}};

    bus_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d, win_idx;
    logic [NDRV-1:0] gnt_q, en_q, en_bar_q, en_d;
    logic [W-1:0]    bus_q;
    logic            bus_vld_q;
    logic [NDRV-1:0] arb_gnt;
    logic            arb_vld;
    logic            own_release;

    gf180mcu_osu_sc_rr_arb #(.NDRV(NDRV)) u_arb (
        .req (REQ),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .vld (arb_vld)
    );

    always_comb begin
        win_idx = ptr_q;
        for (int i = 0; i < NDRV; i++) begin
            if (arb_gnt[i]) win_idx = PW'(i);
        end
    end

    // Owner lets go when its request drops, or when it has used its hold
    // budget and someone else is waiting.
    assign own_release = ~|(REQ & en_q) ||
                         ((MAX_HOLD != 0) && (cnt_q >= HOLD_MAX) && |(REQ & ~en_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = DRIVE;
                    en_d    = arb_gnt;
                    ptr_d   = win_idx;
                    cnt_d   = CW'(1);
                end
            end
            DRIVE: begin
                if (own_release) begin
                    state_d = TURN;
                    en_d    = '0;
                    cnt_d   = CW'(1);
                end else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TURN: begin
                // Requests are only looked at in the final gap cycle.
                if (cnt_q >= DEAD_LAST) begin
                    if (arb_vld) begin
                        state_d = DRIVE;
                        en_d    = arb_gnt;
                        ptr_d   = win_idx;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= PW'(NDRV - 1);
            gnt_q     <= '0;
            bus_q     <= '0;
            bus_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= en_d;
            bus_vld_q <= (state_q == DRIVE);
            if (state_q == DRIVE) bus_q <= BUS_IN;
        end
    end

    // Enable pair: reset clears EN and sets EN_BAR so no tbuf is left on.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) en_q <= '0;
        else     en_q <= en_d;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) en_bar_q <= '1;
        else     en_bar_q <= ~en_d;
    end

    assign GNT     = gnt_q;
    assign EN      = en_q;
    assign EN_BAR  = en_bar_q;
    assign BUS_Q   = bus_q;
    assign BUS_VLD = bus_vld_q;

endmodule
